// File: rtl/int_fp_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// int_fp_mul_arbiter_if
//   Requester-side bundle of the shared int8/fp16 multiplier arbiter.
//   Parameter NUM_REQ sets the number of requester lanes.
//
//   Handshake semantics (both directions): a transfer happens on a rising clk
//   edge where valid[i] and ready[i] are both 1. valid must not depend on
//   ready. The arbiter drives req_ready and rsp_valid as one-hot or zero.
//
//   req_valid  NUM_REQ      per-requester op valid         (master -> slave)
//   req_ready  NUM_REQ      per-requester accept           (slave  -> master)
//   req_mode   NUM_REQ      1 = fp16, 0 = int8             (master -> slave)
//   req_a      16*NUM_REQ   operand A, lane i at [16*i+:16](master -> slave)
//   req_b      16*NUM_REQ   operand B, same packing        (master -> slave)
//   rsp_valid  NUM_REQ      one-hot owner of head result   (slave  -> master)
//   rsp_ready  NUM_REQ      requester accepts result       (master -> slave)
//   rsp_c      16           head result                    (slave  -> master)
//   rsp_error  1            head error flag                (slave  -> master)
// ---------------------------------------------------------------------------
interface int_fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_mode;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [15:0]           rsp_c;
  logic                  rsp_error;

  modport slave (
    input  req_valid, req_mode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_error
  );

  modport master (
    output req_valid, req_mode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_error
  );
endinterface

// File: rtl/int_fp_mul_arbiter.sv
// ---------------------------------------------------------------------------
// int_fp_mul_arbiter
//   Shares one int_fp_mul unit among NUM_REQ requesters. At most one op is
//   issued per cycle, chosen round-robin. A tag pipe of LATENCY stages follows
//   each op through the multiplier; when the tag emerges, the result is pushed
//   into an output FIFO, which returns results strictly in issue order.
//   Issue is credit-limited (ops in flight + FIFO entries < DEPTH), so a
//   result always finds a free FIFO slot.
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   bus (slave)         requester request/response lanes
//   mul_mode/a/b  out   operands to the shared multiplier (0 when idle)
//   mul_c, mul_error in multiplier result, LATENCY cycles after operands
//   err_count     out   saturating count of fp16 results with error set
//   busy          out   an op is in flight or the FIFO holds a result
// ---------------------------------------------------------------------------
module int_fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  int_fp_mul_arbiter_if.slave        bus,
  output logic                       mul_mode,
  output logic [15:0]                mul_a,
  output logic [15:0]                mul_b,
  input  logic [15:0]                mul_c,
  input  logic                       mul_error,
  output logic [15:0]                err_count,
  output logic                       busy
);

  localparam int DEPTH = LATENCY + 2;
  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   cand;
  logic           found;
  logic           issue_ok;
  logic           grant;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    credit_used;

  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign issue_ok    = credit_used < DEPTH_C;

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = cand[IDW-1:0];
      end
    end
  end

  // A grant is always a transfer: ready is only raised where valid is high.
  assign grant = found && issue_ok;

  always_comb begin
    bus.req_ready = '0;
    mul_a         = '0;
    mul_b         = '0;
    mul_mode      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && gnt_id == IDW'(i)) begin
        bus.req_ready[i] = 1'b1;
        mul_a            = bus.req_a[16*i +: 16];
        mul_b            = bus.req_b[16*i +: 16];
        mul_mode         = bus.req_mode[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Tag pipe: {valid, id, mode} travels alongside the multiplier latency
  // ---------------------------------------------------------------------
  logic           push_v;
  logic [IDW-1:0] push_id;
  logic           push_mode;

  generate
    if (LATENCY == 0) begin : g_comb
      // Combinational multiplier: result is captured in the issue cycle.
      assign push_v    = grant;
      assign push_id   = gnt_id;
      assign push_mode = mul_mode;
      assign inflight  = '0;
    end else begin : g_pipe
      logic [LATENCY-1:0] pv;
      logic [LATENCY-1:0] pmode;
      logic [IDW-1:0]     pid [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv       <= '0;
          pmode    <= '0;
          inflight <= '0;
          for (int k = 0; k < LATENCY; k++) pid[k] <= '0;
        end else begin
          pv[0]    <= grant;
          pmode[0] <= mul_mode;
          pid[0]   <= gnt_id;
          for (int k = 1; k < LATENCY; k++) begin
            pv[k]    <= pv[k-1];
            pmode[k] <= pmode[k-1];
            pid[k]   <= pid[k-1];
          end
          inflight <= inflight + CW'(grant) - CW'(pv[LATENCY-1]);
        end
      end

      assign push_v    = pv[LATENCY-1];
      assign push_id   = pid[LATENCY-1];
      assign push_mode = pmode[LATENCY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  logic [15:0]    fifo_c  [DEPTH];
  logic           fifo_e  [DEPTH];
  logic [IDW-1:0] fifo_id [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           nonempty;
  logic [IDW-1:0] head_id;
  logic           pop;
  logic           push_err;

  // The multiplier error flag is only meaningful for fp16 ops.
  assign push_err = mul_error & push_mode;
  assign nonempty = fifo_count != '0;
  assign head_id  = fifo_id[rd_ptr];
  // Only the owner's ready can pop the head; other ready bits are ignored.
  assign pop      = nonempty && bus.rsp_ready[head_id];

  always_ff @(posedge clk) begin
    if (push_v) begin
      fifo_c[wr_ptr]  <= mul_c;
      fifo_e[wr_ptr]  <= push_err;
      fifo_id[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_v) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)    rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push_v) - CW'(pop);
    end
  end

  // Storage is not reset, so outputs are gated by occupancy.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = nonempty && (head_id == IDW'(i));
    end
    bus.rsp_c     = nonempty ? fifo_c[rd_ptr] : 16'h0000;
    bus.rsp_error = nonempty ? fifo_e[rd_ptr] : 1'b0;
  end

  // ---------------------------------------------------------------------
  // Error counter and status
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (push_v && push_err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign busy = (inflight != '0) || nonempty;

  a_fifo_bound : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CW'(DEPTH));

endmodule
